// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_pkg
// Brief    : Shared types and helpers for the seven-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Digit enables are active-low on the board.
    localparam logic c_AN_ON = 1'b0;

    function automatic int cnt_width(input int scan_div);
        return (scan_div > 2) ? $clog2(scan_div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_timer
// Brief    : Phase counter with GAP/SHOW terminal-count flags.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_timer
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_show,
    output logic o_gap_done,
    output logic o_show_done
);

    localparam int c_CNT_W = cnt_width(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SHOW_LAST = c_CNT_W'(SCAN_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign o_gap_done  = !i_show && (r_cnt == c_GAP_LAST);
    assign o_show_done =  i_show && (r_cnt == c_SHOW_LAST);

    // The counter restarts on every phase change, so it never wraps on its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (o_gap_done || o_show_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Double-buffered multi-digit seven-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic [3:0]            nibble,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int c_IDX_W = $clog2(N_DIGITS);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_DIGITS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [4*N_DIGITS-1:0] r_shadow_data;
    logic [N_DIGITS-1:0]   r_shadow_mask;
    logic [4*N_DIGITS-1:0] r_disp_data;
    logic [N_DIGITS-1:0]   r_disp_mask;
    logic [4*N_DIGITS-1:0] w_disp_data_nxt;
    logic [N_DIGITS-1:0]   w_disp_mask_nxt;
    logic                  r_pending;
    logic                  r_frame_done;
    logic [3:0]            r_nibble;
    logic [N_DIGITS-1:0]   r_an_n;
    logic [3:0]            w_nibble_nxt;
    logic [N_DIGITS-1:0]   w_an_n_nxt;
    logic                  w_show;
    logic                  w_gap_done;
    logic                  w_show_done;
    logic                  w_frame_end;

    assign w_show = (r_state == ST_SHOW);

    seg_scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_show      (w_show),
        .o_gap_done  (w_gap_done),
        .o_show_done (w_show_done)
    );

    // Next-state values; outputs are decoded from these so they are registered
    // in step with the state they describe.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_disp_data_nxt = r_disp_data;
        w_disp_mask_nxt = r_disp_mask;
        w_frame_end     = w_show_done && (r_idx == c_IDX_LAST);
        w_nibble_nxt    = '0;
        w_an_n_nxt      = {N_DIGITS{~c_AN_ON}};

        case (r_state)
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_show_done) begin
                    w_state_nxt = ST_GAP;
                    w_idx_nxt   = w_frame_end ? '0 : r_idx + c_IDX_W'(1);
                end
            end
            default: w_state_nxt = ST_GAP;
        endcase

        // Display only swaps at the frame boundary, so a frame never tears.
        if (w_frame_end && r_pending) begin
            w_disp_data_nxt = r_shadow_data;
            w_disp_mask_nxt = r_shadow_mask;
        end

        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_idx_nxt == c_IDX_W'(k)) begin
                w_nibble_nxt = w_disp_data_nxt[4*k +: 4];
                if ((w_state_nxt == ST_SHOW) && !w_disp_mask_nxt[k]) begin
                    w_an_n_nxt[k] = c_AN_ON;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_GAP;
            r_idx         <= '0;
            r_shadow_data <= '0;
            r_shadow_mask <= '0;
            r_disp_data   <= '0;
            r_disp_mask   <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_nibble      <= '0;
            r_an_n        <= {N_DIGITS{~c_AN_ON}};
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_disp_data  <= w_disp_data_nxt;
            r_disp_mask  <= w_disp_mask_nxt;
            r_frame_done <= w_frame_end;
            r_nibble     <= w_nibble_nxt;
            r_an_n       <= w_an_n_nxt;
            // A load on the boundary edge wins over the pending clear.
            if (load) begin
                r_shadow_data <= data_in;
                r_shadow_mask <= blank_in;
                r_pending     <= 1'b1;
            end else if (w_frame_end) begin
                r_pending     <= 1'b0;
            end
        end
    end

    assign nibble     = r_nibble;
    assign an_n       = r_an_n;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl (4 digits, 8/2 cycle slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int SD   = 8;
    localparam int GC   = 2;
    localparam int SLOT = GC + SD;
    localparam int FL   = N * SLOT;

    logic           clk;
    logic           reset;
    logic           load;
    logic [4*N-1:0] data_in;
    logic [N-1:0]   blank_in;
    logic [3:0]     nibble;
    logic [N-1:0]   an_n;
    logic           pending;
    logic           frame_done;

    seg_scan_ctrl #(
        .N_DIGITS   (N),
        .SCAN_DIV   (SD),
        .GAP_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .nibble     (nibble),
        .an_n       (an_n),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an_n;
        logic [3:0] nibble;
        logic       pending;
        logic       frame_done;
    } exp_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  blank;
        logic [15:0] exp_nib;   // digit k expected nibble at [4k+:4]
        logic [15:0] exp_an;    // digit k expected an_n during its SHOW slot
    } vec_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    int          t;
    logic [15:0] m_sh_d;
    logic [3:0]  m_sh_m;
    logic [15:0] m_disp_d;
    logic [3:0]  m_disp_m;
    logic        m_pend;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   p;
        int   d;
        int   s;
        p = t % FL;
        d = p / SLOT;
        s = p % SLOT;
        e.an_n = 4'hF;
        if (s >= GC && !m_disp_m[d]) e.an_n[d] = 1'b0;
        e.nibble     = m_disp_d[4*d +: 4];
        e.pending    = m_pend;
        e.frame_done = (t > 0) && (p == 0);
        return e;
    endfunction

    task automatic model_reset();
        t        = 0;
        m_sh_d   = '0;
        m_sh_m   = '0;
        m_disp_d = '0;
        m_disp_m = '0;
        m_pend   = 1'b0;
    endtask

    // One clock edge: predict the post-edge outputs, then compare them.
    task automatic step();
        exp_t e;
        t++;
        if ((t % FL) == 0 && m_pend) begin
            m_disp_d = m_sh_d;
            m_disp_m = m_sh_m;
            m_pend   = 1'b0;
        end
        if (load) begin
            m_sh_d = data_in;
            m_sh_m = blank_in;
            m_pend = 1'b1;
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        load = 1'b0;
        e = sb_q.pop_front();
        chk("an_n",       16'(an_n),       16'(e.an_n));
        chk("nibble",     16'(nibble),     16'(e.nibble));
        chk("pending",    16'(pending),    16'(e.pending));
        chk("frame_done", 16'(frame_done), 16'(e.frame_done));
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FL; i++) begin
            if ((t % FL) == pos) break;
            step();
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        data_in  = d;
        blank_in = b;
        load     = 1'b1;
        step();
    endtask

    // Starts at frame position 0, ends at position FL-1.
    task automatic check_frame(input string name, input logic [15:0] nib, input logic [15:0] an);
        int d;
        for (int i = 0; i < FL - 1; i++) begin
            step();
            if (((t % FL) % SLOT) == GC + 4) begin
                d = (t % FL) / SLOT;
                chk({name, "_an"},  16'(an_n),   16'(an[4*d +: 4]));
                chk({name, "_nib"}, 16'(nibble), 16'(nib[4*d +: 4]));
            end
        end
    endtask

    vec_t vecs[3];

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        blank_in = '0;
        model_reset();

        vecs[0] = '{data: 16'h1A3F, blank: 4'b0000, exp_nib: 16'h1A3F, exp_an: 16'h7BDE};
        vecs[1] = '{data: 16'h1234, blank: 4'b0100, exp_nib: 16'h1234, exp_an: 16'h7FDE};
        vecs[2] = '{data: 16'hC0DE, blank: 4'b1001, exp_nib: 16'hC0DE, exp_an: 16'hFBDF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_an_n",       16'(an_n),       16'hF);
        chk("rst_nibble",     16'(nibble),     16'h0);
        chk("rst_pending",    16'(pending),    16'h0);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        reset = 1'b0;

        // Idle frame plus the first boundary pulse.
        repeat (FL) step();
        chk("idle_frame_done", 16'(frame_done), 16'h1);

        // Table-driven loads, each shown in the frame after it was written.
        for (int v = 0; v < 3; v++) begin
            run_to(15);
            do_load(vecs[v].data, vecs[v].blank);
            chk("vec_pending", 16'(pending), 16'h1);
            run_to(0);
            chk("vec_swap_pending", 16'(pending), 16'h0);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_nib, vecs[v].exp_an);
        end

        // Two loads in one frame: only the last one is displayed.
        run_to(5);
        do_load(16'hAAAA, 4'b0000);
        run_to(20);
        do_load(16'h5555, 4'b0000);
        run_to(0);
        check_frame("lastwins", 16'h5555, 16'h7BDE);

        // Load on the exact boundary edge.
        run_to(10);
        do_load(16'h1111, 4'b0000);
        run_to(FL - 1);
        do_load(16'hBEEF, 4'b0000);
        chk("bnd_pending_kept", 16'(pending), 16'h1);
        check_frame("bnd_old", 16'h1111, 16'h7BDE);
        chk("bnd_pending_end", 16'(pending), 16'h1);
        step();
        chk("bnd_pending_clr", 16'(pending), 16'h0);
        chk("bnd_frame_done",  16'(frame_done), 16'h1);
        check_frame("bnd_new", 16'hBEEF, 16'h7BDE);

        // Asynchronous reset during digit 2's SHOW with a load pending.
        run_to(5);
        do_load(16'h7777, 4'b0000);
        run_to(2 * SLOT + GC + 3);
        chk("pre_rst_an_n",    16'(an_n),    16'hB);
        chk("pre_rst_pending", 16'(pending), 16'h1);
        reset = 1'b1;
        #1;
        chk("arst_an_n",       16'(an_n),       16'hF);
        chk("arst_nibble",     16'(nibble),     16'h0);
        chk("arst_pending",    16'(pending),    16'h0);
        chk("arst_frame_done", 16'(frame_done), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (GC) step();
        chk("post_rst_digit0", 16'(an_n), 16'hE);
        repeat (FL) step();
        chk("post_rst_nibble",  16'(nibble),  16'h0);
        chk("post_rst_pending", 16'(pending), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d actual=running required=finished", t);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display. Holds a double-buffered hex word, selects one digit at a time onto the shared 4-bit hex decoder input, and drives the active-low digit enables with a blanking gap between digits to suppress ghosting. Sits between register/bus logic (writer side) and the combinational hex-to-segment decoder (display side).

## Interface
- N_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clock cycles each digit is lit (SHOW phase)
- GAP_CYCLES, 16, clock cycles all digits are off between digits; must satisfy 1 ≤ GAP_CYCLES < SCAN_DIV

- clk  in  1  system clock; one clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  single-cycle write strobe for data_in/blank_in
- data_in  in  4*N_DIGITS  hex word; nibble k = digit k (digit 0 = LSB nibble)
- blank_in  in  N_DIGITS  per-digit blank mask; 1 = digit k stays dark
- nibble  out  4  hex value for the shared decoder
- an_n  out  N_DIGITS  digit enables, active-low, at most one low
- pending  out  1  shadow holds data not yet shown
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: shadow (data+mask), display (data+mask), digit index idx, phase counter cnt, state, pending.
- load=1: shadow ← {data_in, blank_in}, pending ← 1. Always accepted; back-to-back loads overwrite, last one wins.
- FSM states: GAP, SHOW.
  - GAP: an_n = all 1s; nibble = display nibble[idx]. After GAP_CYCLES cycles → SHOW, cnt ← 0.
  - SHOW: an_n[idx] = 0 unless display mask[idx] = 1 (then all 1s); nibble = display nibble[idx]. After SCAN_DIV cycles → GAP, cnt ← 0, idx ← idx+1, wrapping N_DIGITS-1 → 0.
- Frame boundary = the edge leaving SHOW with idx = N_DIGITS-1: frame_done pulses for the following cycle; if pending = 1, display ← shadow and pending ← 0 on that edge.
- load on the boundary edge: shadow takes the new value, display takes the previous shadow, pending stays 1; new value shows from the next frame.
- Display never changes mid-frame (no tearing).
- cnt width = $clog2(SCAN_DIV); it is never compared beyond SCAN_DIV-1 and has no free-running wrap.

## Timing
- Reset values: state = GAP, idx = 0, cnt = 0, shadow = 0, display = 0, pending = 0, an_n = all 1s, nibble = 0, frame_done = 0.
- Reset mid-frame: immediately dark; restarts at GAP of digit 0. The pre-reset load is discarded.
- After reset release: GAP_CYCLES cycles dark, then digit 0 is lit for SCAN_DIV cycles.
- Frame length = N_DIGITS × (GAP_CYCLES + SCAN_DIV) cycles.
- Outputs are registered: an_n, nibble, frame_done, and pending all come from flops; no combinational path from the inputs.
- Latency from load to visible: up to one frame plus the first GAP of the next frame.

## Structure
- Shared package: FSM state encoding (ST_GAP, ST_SHOW), the active-low enable polarity constant, and the derived width function for cnt.
- One natural sub-module: seg_scan_timer (phase counter plus GAP/SHOW terminal-count flags). The FSM, buffers, and output registers stay in the top.
- The hex-to-segment decoder is instantiated outside, by the parent.

## Test plan
(N_DIGITS=4, SCAN_DIV=8, GAP_CYCLES=2)
- Reset then idle → an_n = 4'b1111 for 2 cycles, then 4'b1110 for 8 cycles, then digits 1, 2, 3 in turn; frame_done every 40 cycles; nibble = 0 throughout.
- load data_in = 16'h1A3F, blank_in = 0 mid-frame → pending = 1, display unchanged until the boundary; next frame nibble = F, 3, A, 1 for digits 0..3; pending = 0.
- blank_in = 4'b0100 with data 16'h1234 → during digit 2's SHOW slot an_n = 4'b1111 and nibble = 2; the other digits light normally.
- load 16'hAAAA, then load 16'h5555 in the same frame → next frame shows only 5s.
- load 16'hBEEF on the exact boundary edge → the following frame shows the previous shadow; 16'hBEEF appears one frame later; pending stays 1 until then.
- Assert reset during digit 2's SHOW with pending = 1 → an_n = 4'b1111 asynchronously; after release the counters restart at digit 0; display = 0 and pending = 0.
